// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, ALU selects,
// FSM state encoding and the iteration bound.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    function automatic logic is_div(input logic [1:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ALU.sv
// Processor's 32-bit ALU; the sequencer borrows it as its only adder/subtractor.
module ALU
    import muldiv_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  SEL,
    output logic [31:0] C,
    output logic        Zero
);

    always_comb begin
        C = 32'd0;
        case (SEL)
            ALU_ADD: C = A + B;
            ALU_SUB: C = A - B;
            3'b010:  C = A & B;
            3'b011:  C = A | B;
            3'b100:  C = A ^ B;
            3'b101:  C = ~(A | B);
            3'b110:  C = {31'd0, $signed(A) < $signed(B)};
            default: C = {31'd0, A < B};
        endcase
    end

    assign Zero = (C == 32'd0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiply and restoring divide, one iteration per cycle, with all
// add/subtract work routed through the shared ALU.
module alu_muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic        DIV_ZERO,
    output logic [1:0]  dbg_state
);

    muldiv_state_e state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;      // product accumulator or partial remainder
    logic [31:0]   x_q, x_d;          // multiplicand (shifts left) or divisor
    logic [31:0]   y_q, y_d;          // multiplier (shifts right) or dividend/quotient
    logic [31:0]   result_q, result_d;
    logic          div_zero_q, div_zero_d;

    logic [2:0]    alu_sel;
    logic [31:0]   alu_a;
    logic [31:0]   alu_c;
    logic          alu_zero_unused;
    logic [32:0]   sh;
    logic          ge;

    ALU u_alu (
        .A    (alu_a),
        .B    (x_q),
        .SEL  (alu_sel),
        .C    (alu_c),
        .Zero (alu_zero_unused)
    );

    // Divide step: shift the next dividend bit into the remainder and compare at
    // 33 bits, since the shifted remainder can exceed 32 bits.
    assign sh = {acc_q, y_q[31]};
    assign ge = (sh >= {1'b0, x_q});

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        alu_sel    = ALU_ADD;
        alu_a      = acc_q;

        if (is_div(op_q)) begin
            alu_sel = ALU_SUB;
            alu_a   = sh[31:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d       = OP;
                    cnt_d      = 5'd0;
                    acc_d      = 32'd0;
                    div_zero_d = 1'b0;
                    x_d        = is_div(OP) ? B : A;
                    y_d        = is_div(OP) ? A : B;
                    if (OP == OP_MUL || (is_div(OP) && B != 32'd0)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        if (OP == OP_DIVU) begin
                            result_d   = 32'hFFFF_FFFF;
                            div_zero_d = 1'b1;
                        end else if (OP == OP_REMU) begin
                            result_d   = A;
                            div_zero_d = 1'b1;
                        end else begin
                            result_d   = 32'd0;
                        end
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q == OP_MUL) begin
                    if (y_q[0]) acc_d = alu_c;
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                end else begin
                    acc_d = ge ? alu_c : sh[31:0];
                    y_d   = {y_q[30:0], ge};
                end
                // Result is taken from this cycle's next values so it lands on the
                // same edge that enters DONE.
                if (cnt_q == ITER_LAST) begin
                    state_d  = ST_DONE;
                    result_d = (op_q == OP_DIVU) ? y_d : acc_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MUL;
            cnt_q      <= 5'd0;
            acc_q      <= 32'd0;
            x_q        <= 32'd0;
            y_q        <= 32'd0;
            result_q   <= 32'd0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_DONE);
    assign RESULT    = result_q;
    assign DIV_ZERO  = div_zero_q;
    assign dbg_state = state_q;

endmodule
